fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage plus IF/ID pipeline register, directly upstream of decode.
- Holds the PC and drives the instruction-memory address.
- Captures the fetched instruction and PC+2 into IF/ID, which feed decode's ins and PC_2 inputs.
- Takes back from decode: redirect (branch, nextPC), Halt, and the hazard-unit stall.
- Handles bubbles, wrong-path flush, halt freeze and a slow-memory handshake.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INS, 16'h0800, encoding injected into IF/ID on bubble/flush (NOP opcode 00001).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hazard unit: hold PC and IF/ID.
branch  in  1  decode: redirect taken this cycle.
nextPC  in  16  decode: redirect target.
Halt  in  1  decode: HALT is in ID.
imem_addr  out  16  instruction memory address (= PC).
imem_req  out  1  fetch request.
imem_data  in  16  instruction memory read data.
imem_rdy  in  1  imem_data valid this cycle.
ins  out  16  IF/ID instruction.
PC_2  out  16  IF/ID PC+2.
insValid  out  1  IF/ID holds a real (non-bubble) instruction.
halted  out  1  fetch frozen by HALT.
err  out  1  sticky misaligned-PC error.
fetchCount  out  16  optional perf counter.
bubbleCount  out  16  optional perf counter.

Behaviour:
- Registers: PC, ins, PC_2, insValid, halted, err. All are synchronous and update only on the rising edge of clk.
- Reset (rst=1, synchronous):
  - PC=RESET_PC, ins=NOP_INS, PC_2=16'h0000, insValid=0, halted=0, err=0, counters=0.
  - rst overrides every other input.
  - Asserting rst mid-stall, mid-halt or mid-wait restarts cleanly at RESET_PC.
- Combinational outputs:
  - imem_addr=PC.
  - imem_req=~halted.
  - pcInc=PC+16'd2, with wrap: 16'hFFFE -> 16'h0000.
- Per-cycle priority, highest first:
  1. halted=1: PC holds. IF/ID loads NOP_INS, insValid=0.
  2. stall=1: PC and IF/ID hold. branch and Halt are ignored this cycle; decode re-presents them once the stall clears.
  3. Halt=1: halted<=1, PC holds. IF/ID loads NOP_INS, insValid=0 (squashes the younger fetch).
  4. branch=1: PC<=nextPC. IF/ID loads NOP_INS, insValid=0 (one-cycle wrong-path flush). imem_rdy is ignored.
  5. imem_rdy=0: PC holds. IF/ID loads NOP_INS, insValid=0 (bubble).
  6. Otherwise: PC<=pcInc, ins<=imem_data, PC_2<=pcInc, insValid<=1.
- Latency:
  - With imem_rdy tied 1, an instruction fetched at PC appears on ins one cycle later.
  - Taken-redirect penalty is exactly one bubble.
- err: set when imem_req=1 and PC[0]=1. Sticky until rst. Fetch continues unaffected.
- Simultaneous cases:
  - Halt with branch: Halt wins.
  - stall with imem_rdy=1: the fetched data is dropped and the same PC is re-fetched later.
  - Redirect to PC+2: still flushes.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined:
  - fetchCount increments on every IF/ID load with insValid<=1.
  - bubbleCount increments on every IF/ID load with insValid<=0. Held stall cycles do not count.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: both ports are driven 16'h0000 and no counter flops are built.

Test Plan:
- Reset, then imem_rdy=1 with memory returning 16'hA000+addr for 4 cycles -> imem_addr 0,2,4,6; ins 16'hA000,16'hA002,16'hA004; PC_2 2,4,6; insValid=1.
- At PC=6: branch=1, nextPC=16'h0040 -> next cycle ins=16'h0800, insValid=0, imem_addr=16'h0040; following cycle ins=mem[0x40], PC_2=16'h0042.
- stall=1 for 3 cycles at PC=8 with branch=1 asserted throughout -> PC stays 8, ins/PC_2 unchanged, no redirect; stall drops -> normal fetch resumes.
- imem_rdy=0 for 2 cycles at PC=10 -> two NOP bubbles (insValid=0), PC=10 held; imem_rdy=1 -> ins=mem[10], PC_2=12.
- Halt=1 at PC=14 -> halted=1, imem_req=0, ins=16'h0800 forever, PC=14; rst=1 -> PC=0, halted=0.
- PC=16'hFFFE fetch -> PC_2=16'h0000. Redirect to 16'h0003 -> err=1 and stays set. With FETCH_PERF_CNT_EN, counters match valid and bubble load counts.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with the IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address and request, and captures
// the fetched instruction and PC+2 for decode. Handles stall, redirect flush,
// HALT freeze and a not-ready memory.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/bubble counters;
// when it is undefined, fetchCount and bubbleCount are tied to zero and no
// counter flops are built.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INS  = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] nextPC,
  input  logic        Halt,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_data,
  input  logic        imem_rdy,
  output logic [15:0] ins,
  output logic [15:0] PC_2,
  output logic        insValid,
  output logic        halted,
  output logic        err,
  output logic [15:0] fetchCount,
  output logic [15:0] bubbleCount
);

  localparam int unsigned W = 16;

  // Per-cycle action, listed from highest to lowest priority.
  localparam logic [2:0] ACT_FROZEN   = 3'd0;  // already halted
  localparam logic [2:0] ACT_HOLD     = 3'd1;  // hazard stall
  localparam logic [2:0] ACT_HALT     = 3'd2;  // HALT reached decode
  localparam logic [2:0] ACT_REDIRECT = 3'd3;  // taken branch
  localparam logic [2:0] ACT_BUBBLE   = 3'd4;  // memory not ready
  localparam logic [2:0] ACT_FETCH    = 3'd5;  // normal fetch

  logic [W-1:0] pc;
  logic [W-1:0] pc_inc;
  logic [2:0]   act;

  logic [W-1:0] pc_nxt;
  logic [W-1:0] ins_nxt;
  logic [W-1:0] pc2_nxt;
  logic         valid_nxt;
  logic         halted_nxt;
  logic         err_nxt;

  assign imem_addr = pc;
  assign imem_req  = ~halted;
  // PC+2 wraps naturally through the 16-bit adder (16'hFFFE -> 16'h0000).
  assign pc_inc    = pc + W'(2);

  // Resolve which of the prioritised actions applies this cycle.
  always_comb begin
    act = ACT_FETCH;
    if (halted) begin
      act = ACT_FROZEN;
    end else if (stall) begin
      act = ACT_HOLD;
    end else if (Halt) begin
      act = ACT_HALT;
    end else if (branch) begin
      act = ACT_REDIRECT;
    end else if (!imem_rdy) begin
      act = ACT_BUBBLE;
    end
  end

  // Next-state values for PC, IF/ID and status bits.
  always_comb begin
    pc_nxt     = pc;
    ins_nxt    = ins;
    pc2_nxt    = PC_2;
    valid_nxt  = insValid;
    halted_nxt = halted;
    err_nxt    = err | (imem_req & pc[0]);
    case (act)
      ACT_FROZEN: begin
        ins_nxt   = NOP_INS;
        valid_nxt = 1'b0;
      end
      ACT_HOLD: begin
        pc_nxt = pc;
      end
      ACT_HALT: begin
        halted_nxt = 1'b1;
        ins_nxt    = NOP_INS;
        valid_nxt  = 1'b0;
      end
      ACT_REDIRECT: begin
        pc_nxt    = nextPC;
        ins_nxt   = NOP_INS;
        valid_nxt = 1'b0;
      end
      ACT_BUBBLE: begin
        ins_nxt   = NOP_INS;
        valid_nxt = 1'b0;
      end
      ACT_FETCH: begin
        pc_nxt    = pc_inc;
        ins_nxt   = imem_data;
        pc2_nxt   = pc_inc;
        valid_nxt = 1'b1;
      end
      default: begin
        ins_nxt   = NOP_INS;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // PC and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ins      <= NOP_INS;
      PC_2     <= 16'h0000;
      insValid <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      ins      <= ins_nxt;
      PC_2     <= pc2_nxt;
      insValid <= valid_nxt;
      halted   <= halted_nxt;
      err      <= err_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [W-1:0] fetch_cnt;
  logic [W-1:0] bubble_cnt;
  logic         load_valid;
  logic         load_bubble;

  // Every non-stall cycle loads IF/ID, either with a real instruction or a NOP.
  assign load_valid  = (act == ACT_FETCH);
  assign load_bubble = (act != ACT_FETCH) && (act != ACT_HOLD);

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (load_valid && (fetch_cnt != 16'hFFFF)) begin
        fetch_cnt <= fetch_cnt + W'(1);
      end
      if (load_bubble && (bubble_cnt != 16'hFFFF)) begin
        bubble_cnt <= bubble_cnt + W'(1);
      end
    end
  end

  assign fetchCount  = fetch_cnt;
  assign bubbleCount = bubble_cnt;
`else
  assign fetchCount  = 16'h0000;
  assign bubbleCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan walk plus randomized stimulus, checked
// every cycle against a behavioural model of the fetch stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch, Halt, imem_rdy;
  logic [15:0] nextPC, imem_data;
  logic [15:0] imem_addr, ins, PC_2, fetchCount, bubbleCount;
  logic        imem_req, insValid, halted, err;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  logic [15:0] m_pc, m_ins, m_pc2, m_fc, m_bc;
  logic        m_valid, m_halted, m_err;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .nextPC(nextPC),
    .Halt(Halt), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .imem_rdy(imem_rdy), .ins(ins), .PC_2(PC_2),
    .insValid(insValid), .halted(halted), .err(err),
    .fetchCount(fetchCount), .bubbleCount(bubbleCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Model a bubble/NOP load into IF/ID.
  task automatic model_nop();
    m_ins   = 16'h0800;
    m_valid = 1'b0;
    m_bc    = sat_inc(m_bc);
  endtask

  // Apply one clock of stimulus, advance the model, then compare every output.
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] np,
                      input logic h, input logic rd, input logic [15:0] d);
    @(negedge clk);
    rst = r; stall = s; branch = b; nextPC = np; Halt = h; imem_rdy = rd; imem_data = d;
    if (r) begin
      m_pc = 16'h0000; m_ins = 16'h0800; m_pc2 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_fc = 16'h0000; m_bc = 16'h0000;
    end else begin
      if (!m_halted && m_pc[0]) m_err = 1'b1;
      if (m_halted) model_nop();
      else if (s) begin end
      else if (h) begin m_halted = 1'b1; model_nop(); end
      else if (b) begin m_pc = np; model_nop(); end
      else if (!rd) model_nop();
      else begin
        m_ins = d; m_pc = m_pc + 16'd2; m_pc2 = m_pc; m_valid = 1'b1; m_fc = sat_inc(m_fc);
      end
    end
    @(posedge clk);
    #1;
    check("imem_addr", imem_addr, m_pc);
    check("imem_req", 16'(imem_req), 16'(!m_halted));
    check("ins", ins, m_ins);
    check("PC_2", PC_2, m_pc2);
    check("insValid", 16'(insValid), 16'(m_valid));
    check("halted", 16'(halted), 16'(m_halted));
    check("err", 16'(err), 16'(m_err));
`ifdef FETCH_PERF_CNT_EN
    check("fetchCount", fetchCount, m_fc);
    check("bubbleCount", bubbleCount, m_bc);
`else
    check("fetchCount", fetchCount, 16'h0000);
    check("bubbleCount", bubbleCount, 16'h0000);
`endif
  endtask

  // Convenience wrappers for the directed walk.
  task automatic fetch1();
    step(0, 0, 0, 16'h0, 0, 1, mem_word(m_pc));
  endtask

  task automatic redirect(input logic [15:0] tgt);
    step(0, 0, 1, tgt, 0, 1, mem_word(m_pc));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; nextPC = '0; Halt = 1'b0;
    imem_rdy = 1'b0; imem_data = '0;
    m_pc = '0; m_ins = '0; m_pc2 = '0; m_valid = 1'b0; m_halted = 1'b0;
    m_err = 1'b0; m_fc = '0; m_bc = '0;

    // Reset state.
    step(1, 0, 0, 16'h0, 0, 0, 16'h0);
    check("rst_ins_nop", ins, 16'h0800);

    // Straight-line fetch from 0.
    repeat (4) fetch1();
    check("seq_ins", ins, 16'hA006);

    // Redirect to 0x40: one bubble, then target instruction.
    redirect(16'h0040);
    check("redir_nop", ins, 16'h0800);
    fetch1();
    check("redir_pc2", PC_2, 16'h0042);

    // Stall at PC=8 with branch held high: no redirect.
    redirect(16'h0008);
    repeat (3) step(0, 1, 1, 16'h0080, 0, 1, mem_word(m_pc));
    check("stall_addr", imem_addr, 16'h0008);
    fetch1();

    // Memory not ready at PC=10.
    repeat (2) step(0, 0, 0, 16'h0, 0, 0, 16'hDEAD);
    check("bubble_addr", imem_addr, 16'h000A);
    fetch1();
    check("after_bubble_ins", ins, 16'hA00A);

    // HALT at PC=14, frozen until reset.
    fetch1();
    step(0, 0, 1, 16'h0100, 1, 1, mem_word(m_pc));
    repeat (3) step(0, 0, 1, 16'h0200, 0, 1, mem_word(m_pc));
    check("halt_addr", imem_addr, 16'h000E);
    step(1, 0, 0, 16'h0, 0, 1, 16'h0);
    check("rst_after_halt", 16'(halted), 16'h0000);

    // PC+2 wrap and misaligned redirect.
    redirect(16'hFFFE);
    fetch1();
    check("wrap_pc2", PC_2, 16'h0000);
    redirect(16'h0003);
    fetch1();
    check("err_set", 16'(err), 16'h0001);
    repeat (3) fetch1();
    check("err_sticky", 16'(err), 16'h0001);

    // Randomized stimulus, including reset mid-stall/halt/wait.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] np;
      np = 16'($urandom);
      if ($urandom_range(0, 9) != 0) np[0] = 1'b0;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 15, np, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 75, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
